// File: rtl/counter_pkg.sv
// Shared definitions for the counter sequencing controller: state encoding,
// count direction and run-mode constants.
package counter_pkg;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] RUN    = 2'd1;
  localparam logic [1:0] PAUSED = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE   = IDLE,
    S_RUN    = RUN,
    S_PAUSED = PAUSED,
    S_DONE   = DONE
  } state_t;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  localparam logic MODE_ONESHOT  = 1'b0;
  localparam logic MODE_PERIODIC = 1'b1;

endpackage

// File: rtl/counter_if.sv
// Command and status bundle between a software-style controller (master)
// and the counter sequencing block (slave).
interface counter_if #(
  parameter int WIDTH = 4
) ();

  logic             start;
  logic             pause;
  logic             clear;
  logic [WIDTH-1:0] limit;
  logic             dir;
  logic             periodic;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             done;
  logic             wrap;

  modport master (
    output start, pause, clear, limit, dir, periodic,
    input  count, busy, done, wrap
  );

  modport slave (
    input  start, pause, clear, limit, dir, periodic,
    output count, busy, done, wrap
  );

endinterface

// File: rtl/count_core.sv
// Bare WIDTH-bit up/down counter register; all sequencing decisions live in
// counter_ctrl, this block only loads or steps when told to.
module count_core
  import counter_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             dir,
  output logic [WIDTH-1:0] count
);

  // Load has priority over stepping so a reload never also counts.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en) begin
      count <= (dir == DIR_DOWN) ? count - 1'b1 : count + 1'b1;
    end
  end

endmodule

// File: rtl/counter_ctrl.sv
// Sequencing controller: start/pause/clear FSM, latched run parameters,
// terminal compare and registered busy/done/wrap status around count_core.
module counter_ctrl
  import counter_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic     clk,
  input  logic     reset,
  counter_if.slave bus
);

  state_t           state;
  state_t           next_state;
  logic [WIDTH-1:0] limit_q;
  logic             dir_q;
  logic             periodic_q;

  logic             load;
  logic             en;
  logic             latch;
  logic             done_next;
  logic             wrap_next;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] fresh_start;
  logic [WIDTH-1:0] reload_val;
  logic [WIDTH-1:0] terminal;

  // A fresh start uses the live inputs; reloads and terminal checks use only
  // the values latched at that start.
  assign fresh_start = (bus.dir == DIR_DOWN) ? bus.limit : '0;
  assign reload_val  = (dir_q == DIR_DOWN) ? limit_q : '0;
  assign terminal    = (dir_q == DIR_DOWN) ? '0 : limit_q;

  always_comb begin
    next_state = state;
    load       = 1'b0;
    load_val   = reload_val;
    en         = 1'b0;
    latch      = 1'b0;
    done_next  = 1'b0;
    wrap_next  = 1'b0;
    if (bus.clear) begin
      next_state = S_IDLE;
      load       = 1'b1;
      load_val   = '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            next_state = S_RUN;
            load       = 1'b1;
            load_val   = fresh_start;
            latch      = 1'b1;
          end
        end
        S_RUN: begin
          // Pause outranks the terminal action; it fires after resuming.
          if (bus.pause) begin
            next_state = S_PAUSED;
          end else if (bus.count == terminal) begin
            if (periodic_q == MODE_PERIODIC) begin
              load      = 1'b1;
              wrap_next = 1'b1;
            end else begin
              next_state = S_DONE;
              done_next  = 1'b1;
            end
          end else begin
            en = 1'b1;
          end
        end
        S_PAUSED: begin
          if (bus.start) begin
            next_state = S_RUN;
          end
        end
        default: next_state = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      limit_q    <= '0;
      dir_q      <= DIR_UP;
      periodic_q <= MODE_ONESHOT;
      bus.busy   <= 1'b0;
      bus.done   <= 1'b0;
      bus.wrap   <= 1'b0;
    end else begin
      state <= next_state;
      if (latch) begin
        limit_q    <= bus.limit;
        dir_q      <= bus.dir;
        periodic_q <= bus.periodic;
      end
      bus.busy <= (next_state == S_RUN) || (next_state == S_PAUSED);
      bus.done <= done_next;
      bus.wrap <= wrap_next;
    end
  end

  count_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .load_val (load_val),
    .en       (en),
    .dir      (dir_q),
    .count    (bus.count)
  );

endmodule

// File: tb/tb_counter_ctrl.sv
// Self-checking bench for counter_ctrl: directed scenario tasks followed by a
// randomized run scored against a behavioural model.
module tb_counter_ctrl;

  localparam int WIDTH = 4;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   fails  = 0;

  always #5 clk = ~clk;

  counter_if #(.WIDTH(WIDTH)) bus ();

  counter_ctrl #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cmd(input logic s, input logic p, input logic c);
    bus.start = s;
    bus.pause = p;
    bus.clear = c;
  endtask

  task automatic set_cfg(input int lim, input logic d, input logic per);
    bus.limit    = WIDTH'(lim);
    bus.dir      = d;
    bus.periodic = per;
  endtask

  task automatic test_reset();
    set_cmd(0, 0, 0);
    set_cfg(0, 0, 0);
    for (int c = 0; c < 5; c++) begin
      reset = (c < 2);
      tick();
      checks++;
      if ({bus.count, bus.busy, bus.done, bus.wrap} !== {WIDTH'(0), 1'b0, 1'b0, 1'b0}) begin
        fails++;
        $display("[TB] FAIL reset c=%0d: got count=%0d busy=%0b done=%0b wrap=%0b, expected all zero",
                 c, bus.count, bus.busy, bus.done, bus.wrap);
      end
    end
  endtask

  task automatic test_oneshot_up();
    int ec; logic eb, ed;
    set_cfg(5, 0, 0);
    for (int c = 0; c < 8; c++) begin
      set_cmd(c == 0, 0, 0);
      tick();
      ec = (c > 5) ? 5 : c;
      eb = (c <= 5);
      ed = (c == 6);
      checks++;
      if ({bus.count, bus.busy, bus.done, bus.wrap} !== {WIDTH'(ec), eb, ed, 1'b0}) begin
        fails++;
        $display("[TB] FAIL oneshot_up c=%0d: got count=%0d busy=%0b done=%0b wrap=%0b, expected count=%0d busy=%0b done=%0b wrap=0",
                 c, bus.count, bus.busy, bus.done, bus.wrap, ec, eb, ed);
      end
    end
  endtask

  task automatic test_periodic_down();
    int ec; logic eb, ew;
    set_cfg(3, 1, 1);
    for (int c = 0; c < 14; c++) begin
      set_cmd(c == 0, 0, c == 13);
      tick();
      ec = (c == 13) ? 0 : 3 - (c % 4);
      eb = (c != 13);
      ew = (c > 0) && (c < 13) && (c % 4 == 0);
      checks++;
      if ({bus.count, bus.busy, bus.done, bus.wrap} !== {WIDTH'(ec), eb, 1'b0, ew}) begin
        fails++;
        $display("[TB] FAIL periodic_down c=%0d: got count=%0d busy=%0b done=%0b wrap=%0b, expected count=%0d busy=%0b done=0 wrap=%0b",
                 c, bus.count, bus.busy, bus.done, bus.wrap, ec, eb, ew);
      end
    end
  endtask

  task automatic test_pause_resume();
    int ec; logic eb, ed;
    set_cfg(9, 0, 0);
    for (int c = 0; c < 16; c++) begin
      set_cmd((c == 0) || (c == 8), (c >= 5) && (c <= 7), 0);
      tick();
      ec = (c <= 4) ? c : (c <= 8) ? 4 : (c <= 13) ? c - 4 : 9;
      eb = (c <= 13);
      ed = (c == 14);
      checks++;
      if ({bus.count, bus.busy, bus.done, bus.wrap} !== {WIDTH'(ec), eb, ed, 1'b0}) begin
        fails++;
        $display("[TB] FAIL pause_resume c=%0d: got count=%0d busy=%0b done=%0b wrap=%0b, expected count=%0d busy=%0b done=%0b wrap=0",
                 c, bus.count, bus.busy, bus.done, bus.wrap, ec, eb, ed);
      end
    end
  endtask

  task automatic test_clear_mid_run();
    int ec; logic eb;
    set_cfg(12, 0, 0);
    for (int c = 0; c < 10; c++) begin
      set_cmd(c == 0, 0, c == 7);
      tick();
      ec = (c <= 6) ? c : 0;
      eb = (c <= 6);
      checks++;
      if ({bus.count, bus.busy, bus.done, bus.wrap} !== {WIDTH'(ec), eb, 1'b0, 1'b0}) begin
        fails++;
        $display("[TB] FAIL clear_mid_run c=%0d: got count=%0d busy=%0b done=%0b wrap=%0b, expected count=%0d busy=%0b done=0 wrap=0",
                 c, bus.count, bus.busy, bus.done, bus.wrap, ec, eb);
      end
    end
  endtask

  task automatic test_pause_at_terminal();
    int ec; logic eb, ed;
    set_cfg(3, 0, 0);
    for (int c = 0; c < 9; c++) begin
      set_cmd((c == 0) || (c == 6), c == 4, 0);
      tick();
      ec = (c < 3) ? c : 3;
      eb = (c <= 6);
      ed = (c == 7);
      checks++;
      if ({bus.count, bus.busy, bus.done, bus.wrap} !== {WIDTH'(ec), eb, ed, 1'b0}) begin
        fails++;
        $display("[TB] FAIL pause_at_terminal c=%0d: got count=%0d busy=%0b done=%0b wrap=%0b, expected count=%0d busy=%0b done=%0b wrap=0",
                 c, bus.count, bus.busy, bus.done, bus.wrap, ec, eb, ed);
      end
    end
  endtask

  task automatic test_limit_change();
    int ec; logic eb, ed;
    for (int c = 0; c < 14; c++) begin
      if (c == 0) set_cfg(7, 0, 0);
      else if (c < 9) set_cfg(2, 1, 1);
      else set_cfg(2, 0, 0);
      set_cmd((c == 0) || (c == 9), 0, 0);
      tick();
      ec = (c <= 7) ? c : (c == 8) ? 7 : (c <= 11) ? c - 9 : 2;
      eb = (c <= 7) || ((c >= 9) && (c <= 11));
      ed = (c == 8) || (c == 12);
      checks++;
      if ({bus.count, bus.busy, bus.done, bus.wrap} !== {WIDTH'(ec), eb, ed, 1'b0}) begin
        fails++;
        $display("[TB] FAIL limit_change c=%0d: got count=%0d busy=%0b done=%0b wrap=%0b, expected count=%0d busy=%0b done=%0b wrap=0",
                 c, bus.count, bus.busy, bus.done, bus.wrap, ec, eb, ed);
      end
    end
  endtask

  task automatic test_limit_zero();
    logic eb, ed, ew;
    for (int c = 0; c < 8; c++) begin
      set_cfg(0, 0, c >= 3);
      set_cmd((c == 0) || (c == 3), 0, c == 7);
      tick();
      eb = (c == 0) || ((c >= 3) && (c <= 6));
      ed = (c == 1);
      ew = (c >= 4) && (c <= 6);
      checks++;
      if ({bus.count, bus.busy, bus.done, bus.wrap} !== {WIDTH'(0), eb, ed, ew}) begin
        fails++;
        $display("[TB] FAIL limit_zero c=%0d: got count=%0d busy=%0b done=%0b wrap=%0b, expected count=0 busy=%0b done=%0b wrap=%0b",
                 c, bus.count, bus.busy, bus.done, bus.wrap, eb, ed, ew);
      end
    end
  endtask

  // Model phases: 0 idle, 1 counting, 2 held, 3 finished.
  task automatic test_random();
    int   phase = 0;
    int   cnt = 0;
    int   lim = 0;
    logic down = 0;
    logic per = 0;
    logic m_done = 0;
    logic m_wrap = 0;
    logic m_busy;
    for (int c = 0; c < 600; c++) begin
      reset = ($urandom_range(0, 99) == 0);
      set_cmd($urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 29) == 0);
      set_cfg($urandom_range(0, 6), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      if (reset) begin
        phase = 0; cnt = 0; lim = 0; down = 0; per = 0; m_done = 0; m_wrap = 0;
      end else if (bus.clear) begin
        phase = 0; cnt = 0; m_done = 0; m_wrap = 0;
      end else begin
        m_done = 0;
        m_wrap = 0;
        if ((phase == 0 || phase == 3) && bus.start) begin
          lim = int'(bus.limit); down = bus.dir; per = bus.periodic;
          cnt = down ? lim : 0;
          phase = 1;
        end else if (phase == 1) begin
          if (bus.pause) phase = 2;
          else if (cnt == (down ? 0 : lim)) begin
            if (per) begin cnt = down ? lim : 0; m_wrap = 1; end
            else begin phase = 3; m_done = 1; end
          end else cnt = down ? cnt - 1 : cnt + 1;
        end else if (phase == 2 && bus.start) begin
          phase = 1;
        end
      end
      m_busy = (phase == 1) || (phase == 2);
      tick();
      checks++;
      if ({bus.count, bus.busy, bus.done, bus.wrap} !== {WIDTH'(cnt), m_busy, m_done, m_wrap}) begin
        fails++;
        $display("[TB] FAIL random c=%0d: got count=%0d busy=%0b done=%0b wrap=%0b, expected count=%0d busy=%0b done=%0b wrap=%0b",
                 c, bus.count, bus.busy, bus.done, bus.wrap, cnt, m_busy, m_done, m_wrap);
      end
    end
    reset = 0;
  endtask

  initial begin
    reset = 1'b1;
    $display("[TB] counter_ctrl bench starting");
    test_reset();
    test_oneshot_up();
    test_periodic_down();
    test_pause_resume();
    test_clear_mid_run();
    test_pause_at_terminal();
    test_limit_change();
    test_limit_zero();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/counter_ctrl.md
# counter_ctrl

Sequencing controller for the team's WIDTH-bit counter datapath. It accepts start/pause/clear commands, runs the counter up or down against a programmable limit, and handles one-shot and periodic (auto-reload) operation. It reports status as busy, a done pulse and a wrap pulse. It sits between software-style control strobes and the bare counter, so the counter never free-runs unsupervised.

## Interface
- WIDTH, 4, counter and limit width in bits
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-high; returns block to IDLE
- start  input  1  level sampled each edge; begins a run from IDLE/DONE, resumes from PAUSED
- pause  input  1  freezes an active run
- clear  input  1  aborts any activity, returns to IDLE with count 0
- limit  input  WIDTH  terminal/start value, latched on start from IDLE/DONE
- dir  input  1  0 = count up 0→limit, 1 = count down limit→0; latched with limit
- periodic  input  1  0 = one-shot, 1 = auto-reload; latched with limit
- count  output  WIDTH  current counter value
- busy  output  1  high in RUN or PAUSED
- done  output  1  one-cycle pulse on one-shot completion
- wrap  output  1  one-cycle pulse on each periodic reload

## Operation
- States: IDLE, RUN, PAUSED, DONE.
- Command priority: reset > clear > start > pause.
- IDLE: count holds its value. start loads count with the start value (0 if dir=0, limit if dir=1), latches limit/dir/periodic, and moves to RUN.
- RUN: count steps ±1 per cycle. Terminal value = latched limit (up) or 0 (down).
  - Count at terminal, one-shot: next state DONE, count holds terminal, done=1 for that first DONE cycle.
  - Count at terminal, periodic: count reloads start value, wrap=1 for one cycle, stays RUN.
  - start is ignored. pause moves to PAUSED; count holds and the terminal check is suppressed that cycle.
- PAUSED: count holds. start returns to RUN with no reload; counting resumes from the held value.
- DONE: count holds terminal. start restarts exactly as from IDLE and re-latches inputs; pause is ignored.
- clear from any state: IDLE, count=0, done=0, wrap=0.
- limit, dir and periodic changes are invisible until the next start from IDLE/DONE.
- Arithmetic: modulo 2^WIDTH, but the terminal check guarantees no wrap past limit/0 in normal operation.

## Timing
- Reset values: state IDLE, count 0, busy 0, done 0, wrap 0, latched limit 0, dir 0, periodic 0.
- All outputs are registered; no combinational input→output paths.
- start sampled at edge k: count = start value and busy=1 after edge k.
- One-shot, up, limit L: count = L after edge k+L. After edge k+L+1: DONE, done=1, busy=0.
- Periodic: period L+1 cycles. wrap is high in the cycles where count has just reloaded.
- limit=0: one-shot completes after edge k+1; periodic asserts wrap every cycle with count=0.
- Reset or clear mid-run takes effect at the same edge. A done or wrap pulse due at that edge is suppressed.
- Simultaneous pause and terminal count: pause wins. On resume, the terminal action fires one cycle later.

## Structure
- Shared package counter_pkg: state encoding (2-bit localparams IDLE/RUN/PAUSED/DONE), DIR_UP/DIR_DOWN and MODE_ONESHOT/MODE_PERIODIC constants.
- Sub-module count_core: WIDTH-bit register with load, load_val, en and dir inputs, no control logic.
- counter_ctrl holds the FSM, input latches, terminal compare and pulse generation.

## Test plan
- Reset 1 for 2 cycles, then 0 -> count=0, busy=0, done=0, wrap=0, state stays IDLE with no commands.
- start with limit=5, dir=0, periodic=0 -> count 0,1,2,3,4,5 on successive cycles, then done=1 for exactly one cycle, busy=0, count holds 5.
- start with limit=3, dir=1, periodic=1 -> count 3,2,1,0,3,2,…, wrap=1 each time count reloads to 3, period 4 cycles, busy stays 1.
- limit=9, up; pause at count=4 for 3 cycles, then start -> count holds 4 while paused, resumes at 5, done after count 9.
- Mid-run clear at count=6 (limit=12); separately, pause asserted in the same cycle count reaches terminal -> clear: count=0, IDLE, no done. Pause case: no done until resume, then done one cycle after resume.
- Change limit from 7 to 2 during a run, then restart from DONE with limit=2 -> first run still ends at 7, second run ends at 2. Also limit=0 one-shot -> done one cycle after start.
